csa_resolve_adder: RTL and testbench

// Final carry-propagate stage placed directly after carry_save_adder. Takes one

---
 rtl/csa_resolve_adder_if.sv | 23 ++
 rtl/csa_resolve_adder.sv | 92 +++++++++
 tb/tb_csa_resolve_adder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/csa_resolve_adder_if.sv
// Handshake bundle between a carry-save adder tree and its resolve stage.
// The producer/consumer side uses master; the resolve adder uses slave.
interface csa_resolve_adder_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] sum_in;
    logic [WIDTH-1:0] carry_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH+1:0] result;

    modport master (
        output in_valid, sum_in, carry_in, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, sum_in, carry_in, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/csa_resolve_adder.sv
// Two-stage carry-propagate adder resolving a redundant (sum, carry) pair into
// result = sum + (carry << 1). Stage 1 adds the low SPLIT bits, stage 2 adds the
// upper bits plus the stage-1 carry-out. Valid/ready flow control, 2 pairs deep.
module csa_resolve_adder #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SPLIT = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    csa_resolve_adder_if.slave  bus
);
    localparam int unsigned HW = WIDTH - SPLIT;

    // Pipeline control
    logic w_s2_adv;
    logic w_s1_adv;
    logic w_accept;

    // Stage-1 arithmetic
    logic [SPLIT-1:0] w_carry_lo;
    logic [SPLIT:0]   w_lo;

    // Stage-2 arithmetic
    logic [HW+1:0]    w_hi;

    // Stage registers
    logic             r_s1_valid;
    logic [SPLIT-1:0] r_s1_lo;
    logic             r_s1_c1;
    logic [HW-1:0]    r_s1_sum_hi;
    logic [HW:0]      r_s1_carry_hi;
    logic             r_s2_valid;
    logic [WIDTH+1:0] r_result;

    // A stage may advance when it is empty or its downstream advances; in_ready
    // therefore depends combinationally on out_ready but never on in_valid.
    assign w_s2_adv     = !r_s2_valid || bus.out_ready;
    assign w_s1_adv     = !r_s1_valid || w_s2_adv;
    assign w_accept     = bus.in_valid && w_s1_adv;
    assign bus.in_ready = w_s1_adv;

    // Carry bit i weighs 2^(i+1), so only carry[SPLIT-2:0] lands in the low slice.
    if (SPLIT > 1) begin : gen_carry_lo
        assign w_carry_lo = {bus.carry_in[SPLIT-2:0], 1'b0};
    end else begin : gen_no_carry_lo
        assign w_carry_lo = '0;
    end

    assign w_lo = {1'b0, bus.sum_in[SPLIT-1:0]} + {1'b0, w_carry_lo};

    // Upper slice: sum_hi and carry_hi are aligned at weight 2^SPLIT; the two
    // extra bits hold the full-width carry-out so nothing is truncated.
    assign w_hi = {2'b00, r_s1_sum_hi} + {1'b0, r_s1_carry_hi} + {{(HW + 1){1'b0}}, r_s1_c1};

    // Stage 1: capture low partial sum and the unresolved upper operands on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid    <= 1'b0;
            r_s1_lo       <= '0;
            r_s1_c1       <= 1'b0;
            r_s1_sum_hi   <= '0;
            r_s1_carry_hi <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_lo       <= w_lo[SPLIT-1:0];
                r_s1_c1       <= w_lo[SPLIT];
                r_s1_sum_hi   <= bus.sum_in[WIDTH-1:SPLIT];
                r_s1_carry_hi <= bus.carry_in[WIDTH-1:SPLIT-1];
            end
        end
    end

    // Stage 2: finish the upper add; result holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_result   <= '0;
        end else if (w_s2_adv) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= {w_hi, r_s1_lo};
            end
        end
    end

    assign bus.out_valid = r_s2_valid;
    assign bus.result    = r_result;

    logic w_unused;
    assign w_unused = w_accept;
endmodule

// File: tb/tb_csa_resolve_adder.sv
// Scoreboard bench for csa_resolve_adder: expected results are queued when a
// pair is accepted and compared in order when the result is transferred out.
module tb_csa_resolve_adder;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned RW    = WIDTH + 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    csa_resolve_adder_if #(.WIDTH(WIDTH)) bus ();

    csa_resolve_adder #(
        .WIDTH (WIDTH),
        .SPLIT (8)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int            cyc = 0;
    logic [RW-1:0] sb[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_out    = 0;
    int            t_first_out = 0;
    int            t_last_out  = 0;
    bit            arm_first   = 1'b0;
    bit            prev_stall  = 1'b0;
    logic [RW-1:0] prev_result;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [RW-1:0] model(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c);
        logic [RW-1:0] a;
        logic [RW-1:0] b;
        a = {2'b00, s};
        b = {2'b00, c};
        return a + (b << 1);
    endfunction

    // Output monitor: pops on transfer, checks stability while stalled.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", 32'(bus.out_valid), 32'd1);
                check_eq("stall_result", 32'(bus.result), 32'(prev_result));
            end
            if (bus.out_valid && bus.out_ready) begin
                check_eq("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check_eq("result", 32'(bus.result), 32'(sb.pop_front()));
                n_out++;
                if (arm_first) begin
                    t_first_out = cyc;
                    arm_first   = 1'b0;
                end
                t_last_out = cyc;
            end
            prev_stall  = bus.out_valid && !bus.out_ready;
            prev_result = bus.result;
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] c,
                        input logic [RW-1:0] exp, output int t_acc);
        bit accepted;
        accepted     = 1'b0;
        t_acc        = 0;
        bus.in_valid = 1'b1;
        bus.sum_in   = s;
        bus.carry_in = c;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(exp);
                t_acc    = cyc;
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
            if (accepted) break;
        end
        bus.in_valid = 1'b0;
        check_eq("send_accepted", 32'(accepted), 32'd1);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        check_eq("drain_empty", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            t_acc;
        int            t0;
        int            n0;
        int            nacc;
        logic [WIDTH-1:0] s;
        logic [WIDTH-1:0] c;

        // Reset with in_valid asserted
        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.sum_in    = 16'hFFFF;
        bus.carry_in  = 16'hFFFF;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_result", 32'(bus.result), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Directed arithmetic
        send(16'h0000, 16'h0000, 18'h00000, t_acc);
        send(16'h00FF, 16'h0001, 18'h00101, t_acc);
        send(16'hFFFF, 16'hFFFF, 18'h2FFFD, t_acc);
        send(16'h1234, 16'h8000, 18'h11234, t_acc);
        drain();

        // Streaming 100 back-to-back pairs
        n0        = n_out;
        arm_first = 1'b1;
        t0        = 0;
        for (int i = 0; i < 100; i++) begin
            s = 16'($urandom);
            c = 16'($urandom);
            send(s, c, model(s, c), t_acc);
            if (i == 0) t0 = t_acc;
        end
        drain();
        check_eq("stream_count", 32'(n_out - n0), 32'd100);
        check_eq("stream_latency", 32'(t_first_out - t0), 32'd2);
        check_eq("stream_rate", 32'(t_last_out - t_first_out), 32'd99);

        // Backpressure: only two pairs fit
        bus.out_ready = 1'b0;
        nacc          = 0;
        s = 16'($urandom);
        c = 16'($urandom);
        repeat (5) begin
            bus.in_valid = 1'b1;
            bus.sum_in   = s;
            bus.carry_in = c;
            @(negedge clk);
            if (bus.in_ready) begin
                sb.push_back(model(s, c));
                nacc++;
                s = 16'($urandom);
                c = 16'($urandom);
            end
            @(posedge clk);
            #1;
        end
        check_eq("bp_accepted", 32'(nacc), 32'd2);
        check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Random valid/ready
        for (int i = 0; i < 1000; i++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid  = 1'($urandom_range(0, 1));
            bus.sum_in    = 16'($urandom);
            bus.carry_in  = 16'($urandom);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.sum_in, bus.carry_in));
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        // Reset with two pairs in flight
        bus.out_ready = 1'b0;
        send(16'hAAAA, 16'h5555, model(16'hAAAA, 16'h5555), t_acc);
        send(16'h0F0F, 16'hF0F0, model(16'h0F0F, 16'hF0F0), t_acc);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("midrst_result", 32'(bus.result), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        rst_n         = 1'b1;
        @(negedge clk);
        check_eq("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        n0 = n_out;
        send(16'h1357, 16'h2468, model(16'h1357, 16'h2468), t_acc);
        drain();
        repeat (3) @(posedge clk);
        #1;
        check_eq("midrst_out_count", 32'(n_out - n0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
